// File: rtl/gerador_de_sequencia_gen.sv
// Serial pattern generator: sends a latched SEQ_W-bit pattern MSB first, one bit per cycle, then pulses done.
// Optional macro GERADOR_REPEAT_EN adds the reps port and resends the pattern reps+1 times back-to-back.
module gerador_de_sequencia_gen #(
    parameter int SEQ_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEQ_W-1:0] seq,
`ifdef GERADOR_REPEAT_EN
    input  logic [REP_W-1:0] reps,
`endif
    input  logic             start,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(SEQ_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t           state_q;
    logic [SEQ_W-1:0] pat_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             out_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
`ifdef GERADOR_REPEAT_EN
    logic [REP_W-1:0] rep_q;
`endif

    // idx_q always names the bit currently on the line; idx_d is the next one.
    assign idx_d = idx_q - IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            idx_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GERADOR_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q     <= SEND;
                        pat_q       <= seq;
                        idx_q       <= LAST_IDX;
                        out_q       <= seq[SEQ_W-1];
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef GERADOR_REPEAT_EN
                        rep_q       <= reps;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state_q     <= IDLE;
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (idx_q == '0) begin
`ifdef GERADOR_REPEAT_EN
                        if (rep_q != '0) begin
                            rep_q <= rep_q - REP_W'(1);
                            idx_q <= LAST_IDX;
                            out_q <= pat_q[SEQ_W-1];
                        end else
`endif
                        begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            out_q       <= 1'b0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_d;
                        out_q <= pat_q[idx_d];
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
